// File: rtl/control_step_sequencer_if.sv
// Bundle between the hardwired control unit and its step sequencer.
// Carries the step controls in one direction and the step vector and status back.
`timescale 1ns/1ps
interface control_step_sequencer_if #(
    parameter int unsigned STEP_W  = 8,
    parameter int unsigned N_STEPS = 256,
    parameter int unsigned ICNT_W  = 32
);
    logic                inc_cnt;
    logic                ld_cnt;
    logic [STEP_W-1:0]   br_target;
    logic                cl_cnt;
    logic                mem_wait;
    logic                halt_req;
    logic [N_STEPS-1:0]  T;
    logic [STEP_W-1:0]   step;
    logic                halted;
    logic [ICNT_W-1:0]   instr_cnt;

    modport master (
        output inc_cnt, ld_cnt, br_target, cl_cnt, mem_wait, halt_req,
        input  T, step, halted, instr_cnt
    );

    modport slave (
        input  inc_cnt, ld_cnt, br_target, cl_cnt, mem_wait, halt_req,
        output T, step, halted, instr_cnt
    );
endinterface

// File: rtl/control_step_sequencer.sv
// Step counter and one-hot step decoder for the hardwired control unit.
// state   | meaning
// RUN     | CNT advances/branches/stalls, T[CNT] is the only active step
// HALT    | CNT parked at the fetch step, T all zeros; left only by rst
`timescale 1ns/1ps
module control_step_sequencer #(
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned N_STEPS    = 256,
    parameter int unsigned FETCH_STEP = 0,
    parameter int unsigned ICNT_W     = 32
) (
    input logic                     clk,
    input logic                     rst,
    control_step_sequencer_if.slave bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [STEP_W-1:0] FETCH = STEP_W'(FETCH_STEP);

    state_t              state;
    logic [STEP_W-1:0]   cnt;
    logic [ICNT_W-1:0]   icnt;
    logic                halted_q;

    // mem_wait freezes everything, including a pending end-of-instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            cnt      <= FETCH;
            icnt     <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!bus.mem_wait) begin
                        if (bus.cl_cnt) begin
                            cnt  <= FETCH;
                            icnt <= icnt + ICNT_W'(1);
                            if (bus.halt_req) begin
                                state    <= ST_HALT;
                                halted_q <= 1'b1;
                            end
                        end else if (bus.ld_cnt) begin
                            cnt <= bus.br_target;
                        end else if (bus.inc_cnt) begin
                            cnt <= cnt + STEP_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    cnt      <= FETCH;
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    cnt      <= FETCH;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.T = '0;
        if (state == ST_RUN) begin
            bus.T[cnt] = 1'b1;
        end
    end

    assign bus.step      = cnt;
    assign bus.halted    = halted_q;
    assign bus.instr_cnt = icnt;
endmodule

// File: tb/tb_control_step_sequencer.sv
// Bench for control_step_sequencer: directed scenarios plus a long random run
// compared cycle by cycle against a plain arithmetic model of the step rules.
`timescale 1ns/1ps
module tb_control_step_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    control_step_sequencer_if #(.STEP_W(8), .N_STEPS(256), .ICNT_W(32)) bus ();

    control_step_sequencer #(
        .STEP_W(8), .N_STEPS(256), .FETCH_STEP(0), .ICNT_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int          m_step;
    bit          m_halted;
    logic [31:0] m_icnt;

    task automatic model_reset();
        m_step   = 0;
        m_halted = 1'b0;
        m_icnt   = '0;
    endtask

    task automatic model_apply(input bit inc, input bit ld, input int tgt,
                               input bit cl, input bit mw, input bit hr);
        if (!m_halted && !mw) begin
            if (cl) begin
                m_step = 0;
                m_icnt = m_icnt + 32'd1;
                if (hr) m_halted = 1'b1;
            end else if (ld) begin
                m_step = tgt;
            end else if (inc) begin
                m_step = (m_step + 1) % 256;
            end
        end
    endtask

    task automatic cycle(input bit inc, input bit ld, input int tgt,
                         input bit cl, input bit mw, input bit hr);
        bus.inc_cnt   = inc;
        bus.ld_cnt    = ld;
        bus.br_target = 8'(tgt);
        bus.cl_cnt    = cl;
        bus.mem_wait  = mw;
        bus.halt_req  = hr;
        model_apply(inc, ld, tgt, cl, mw, hr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inc_cnt   = 1'b0;
        bus.ld_cnt    = 1'b0;
        bus.br_target = '0;
        bus.cl_cnt    = 1'b0;
        bus.mem_wait  = 1'b0;
        bus.halt_req  = 1'b0;
    endtask

    // reset pulse placed between clock edges
    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #4;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.step !== 8'd0) begin
            n_fail++; $display("FAIL reset_step got %0d want 0", bus.step);
        end
        n_cmp++;
        if (bus.T !== 256'h1) begin
            n_fail++; $display("FAIL reset_T got %h want 1", bus.T);
        end
        n_cmp++;
        if (bus.halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_halted got %b want 0", bus.halted);
        end
        n_cmp++;
        if (bus.instr_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_icnt got %0d want 0", bus.instr_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_linear();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.step !== 8'd5) begin
            n_fail++; $display("FAIL linear_step got %0d want 5", bus.step);
        end
        n_cmp++;
        if (bus.T[5] !== 1'b1 || $countones(bus.T) != 1) begin
            n_fail++; $display("FAIL linear_T got %h want only bit 5", bus.T);
        end
    endtask

    task automatic test_branch();
        logic [31:0] icnt_before;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 42, 0, 0, 0);
        n_cmp++;
        if (bus.step !== 8'd42) begin
            n_fail++; $display("FAIL branch_ld_over_inc got %0d want 42", bus.step);
        end
        cycle(0, 1, 255, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.step !== 8'd0 || bus.T !== 256'h1) begin
            n_fail++; $display("FAIL branch_wrap got %0d want 0", bus.step);
        end
        cycle(1, 0, 0, 0, 0, 0);
        icnt_before = bus.instr_cnt;
        cycle(0, 1, 99, 1, 0, 0);
        n_cmp++;
        if (bus.step !== 8'd0) begin
            n_fail++; $display("FAIL branch_cl_over_ld got %0d want 0", bus.step);
        end
        n_cmp++;
        if (bus.instr_cnt !== icnt_before + 32'd1) begin
            n_fail++; $display("FAIL branch_cl_icnt got %0d want %0d", bus.instr_cnt, icnt_before + 32'd1);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 1, 0);
            n_cmp++;
            if (bus.step !== 8'd2) begin
                n_fail++; $display("FAIL wait_hold[%0d] got %0d want 2", i, bus.step);
            end
        end
        cycle(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.step !== 8'd3) begin
            n_fail++; $display("FAIL wait_release got %0d want 3", bus.step);
        end
        cycle(0, 1, 77, 1, 1, 1);
        n_cmp++;
        if (bus.step !== 8'd3 || bus.instr_cnt !== 32'd0 || bus.halted !== 1'b0) begin
            n_fail++; $display("FAIL wait_cl_ignored got step=%0d icnt=%0d halted=%b want 3/0/0",
                               bus.step, bus.instr_cnt, bus.halted);
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 1, 0, 0);
        end
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 1);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.T !== '0) begin
            n_fail++; $display("FAIL halt_enter got halted=%b T=%h want 1/0", bus.halted, bus.T);
        end
        n_cmp++;
        if (bus.instr_cnt !== 32'd4 || bus.step !== 8'd0) begin
            n_fail++; $display("FAIL halt_icnt got icnt=%0d step=%0d want 4/0", bus.instr_cnt, bus.step);
        end
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 33, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (bus.step !== 8'd0 || bus.instr_cnt !== 32'd4 || bus.T !== '0 || bus.halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_frozen got step=%0d icnt=%0d halted=%b want 0/4/1",
                               bus.step, bus.instr_cnt, bus.halted);
        end
        do_reset();
        n_cmp++;
        if (bus.halted !== 1'b0 || bus.step !== 8'd0 || bus.T !== 256'h1) begin
            n_fail++; $display("FAIL halt_exit got halted=%b step=%0d want 0/0", bus.halted, bus.step);
        end
    endtask

    task automatic test_random();
        int halt_cycles;
        logic [255:0] exp_t;
        do_reset();
        halt_cycles = 0;
        for (int i = 0; i < 10000; i++) begin
            cycle(bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0));
            exp_t = m_halted ? '0 : (256'd1 << m_step);
            n_cmp++;
            if (bus.step !== 8'(m_step)) begin
                n_fail++; $display("FAIL rand_step cyc=%0d got %0d want %0d", i, bus.step, m_step);
            end
            n_cmp++;
            if (bus.T !== exp_t) begin
                n_fail++; $display("FAIL rand_T cyc=%0d got %h want %h", i, bus.T, exp_t);
            end
            n_cmp++;
            if (bus.halted !== m_halted) begin
                n_fail++; $display("FAIL rand_halted cyc=%0d got %b want %b", i, bus.halted, m_halted);
            end
            n_cmp++;
            if (bus.instr_cnt !== m_icnt) begin
                n_fail++; $display("FAIL rand_icnt cyc=%0d got %0d want %0d", i, bus.instr_cnt, m_icnt);
            end
            if (m_halted) halt_cycles++;
            if (halt_cycles > 10) begin
                halt_cycles = 0;
                do_reset();
            end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_linear();
        test_branch();
        test_mem_wait();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
